// File: rtl/des_key_sched.sv
// DES key schedule: loads a 64-bit key, then presents the 16 round subkeys
// one per valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
// Optional feature: define DES_KEY_SCHED_WEAK_CHK_EN to flag the four DES weak keys.
module des_key_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] key_in,
    input  logic        key_load,
    input  logic        decrypt,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        weak_key
);

    localparam int unsigned KEY_W  = 64;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned HALF_W = 28;
    localparam int unsigned SUB_W  = 48;
    localparam int unsigned RND_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // PC-1: FIPS key bit numbers (1 = MSB) feeding C1..C28, D1..D28
    localparam byte unsigned PC1_TBL [CD_W] = '{
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
        8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
        8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
        8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
        8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    // PC-2: CD bit numbers (1 = C1) feeding subkey bits 1..48
    localparam byte unsigned PC2_TBL [SUB_W] = '{
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
        8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
        8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
        8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
        8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        logic [5:0]      src;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src = 6'(64 - int'(PC1_TBL[i]));
            r[6'(55 - i)] = k[src];
        end
        return r;
    endfunction

    function automatic logic [SUB_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUB_W-1:0] r;
        logic [5:0]       src;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            src = 6'(56 - int'(PC2_TBL[i]));
            r[6'(47 - i)] = cd[src];
        end
        return r;
    endfunction

    // DES rounds 1, 2, 9 and 16 shift by one; all others by two
    function automatic logic single_shift(input logic [4:0] des_round);
        return (des_round == 5'd1) || (des_round == 5'd2) ||
               (des_round == 5'd9) || (des_round == 5'd16);
    endfunction

    function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] c,
                                              input logic left, input logic one);
        if (left)
            return one ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
        else
            return one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
    endfunction

    state_t             state, state_nxt;
    logic [HALF_W-1:0]  c_q, d_q, c_nxt, d_nxt;
    logic [RND_W-1:0]   rnd_nxt;
    logic               dec_q, dec_nxt;
    logic               valid_nxt, busy_nxt, done_nxt;
    logic               adv_one;
    logic [CD_W-1:0]    cd_load;

    assign cd_load = pc1(key_in);
    assign subkey  = pc2({c_q, d_q});

    // Encrypt steps to DES round r+2; decrypt steps back from round 16-r
    assign adv_one = dec_q ? single_shift(5'd16 - 5'(round_idx))
                           : single_shift(5'(round_idx) + 5'd2);

    // Next-state, C/D advance and registered-output decode
    always_comb begin
        state_nxt = state;
        c_nxt     = c_q;
        d_nxt     = d_q;
        rnd_nxt   = round_idx;
        dec_nxt   = dec_q;
        case (state)
            IDLE: begin
                if (key_load) begin
                    state_nxt = GEN;
                    dec_nxt   = decrypt;
                    rnd_nxt   = '0;
                    if (decrypt) begin
                        c_nxt = cd_load[55:28];
                        d_nxt = cd_load[27:0];
                    end else begin
                        c_nxt = rot(cd_load[55:28], 1'b1, 1'b1);
                        d_nxt = rot(cd_load[27:0], 1'b1, 1'b1);
                    end
                end
            end
            GEN: begin
                if (subkey_valid && subkey_ready) begin
                    if (round_idx == 4'd15) begin
                        state_nxt = FIN;
                    end else begin
                        rnd_nxt = round_idx + 4'd1;
                        c_nxt   = rot(c_q, !dec_q, adv_one);
                        d_nxt   = rot(d_q, !dec_q, adv_one);
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        valid_nxt = (state_nxt == GEN);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == FIN);
    end

    // State, key halves and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            c_q          <= '0;
            d_q          <= '0;
            round_idx    <= '0;
            dec_q        <= 1'b0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            c_q          <= c_nxt;
            d_q          <= d_nxt;
            round_idx    <= rnd_nxt;
            dec_q        <= dec_nxt;
            subkey_valid <= valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

`ifdef DES_KEY_SCHED_WEAK_CHK_EN
    localparam logic [KEY_W-1:0] PARITY_MASK = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [KEY_W-1:0] WEAK_0      = 64'h0101_0101_0101_0101;
    localparam logic [KEY_W-1:0] WEAK_1      = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [KEY_W-1:0] WEAK_2      = 64'hE0E0_E0E0_F1F1_F1F1;
    localparam logic [KEY_W-1:0] WEAK_3      = 64'h1F1F_1F1F_0E0E_0E0E;

    logic [KEY_W-1:0] key_masked;
    logic             key_is_weak;

    assign key_masked  = key_in & PARITY_MASK;
    assign key_is_weak = (key_masked == (WEAK_0 & PARITY_MASK)) ||
                         (key_masked == (WEAK_1 & PARITY_MASK)) ||
                         (key_masked == (WEAK_2 & PARITY_MASK)) ||
                         (key_masked == (WEAK_3 & PARITY_MASK));

    // Weak-key flag captured on each accepted key load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            weak_key <= 1'b0;
        else if (state == IDLE && key_load)
            weak_key <= key_is_weak;
    end
`else
    assign weak_key = 1'b0;
`endif

endmodule
